// File: rtl/hazard_unit_mc_pkg.sv
// Shared types and constants for the multi-cycle hazard unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam int MD_CNT_W = 4;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Hazard-unit bundle between the datapath (master) and the hazard unit (slave).
interface hazard_unit_mc_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic              RegWriteE, RegWriteM, RegWriteW;
  logic [1:0]        ResultSrcE;
  logic              PCSrcE, MulDivE, MemWaitM;
  logic              StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE, FlushM, FlushW;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              MdBusy, MdDoneE;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulDivE, MemWaitM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
    input  ForwardAE, ForwardBE, MdBusy, MdDoneE
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulDivE, MemWaitM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
    output ForwardAE, ForwardBE, MdBusy, MdDoneE
  );
endinterface

// File: rtl/hazard_unit_mc_md_stall_ctr.sv
// MUL/DIV EX-occupancy FSM: holds the front end for MD_LAT cycles and
// stretches the final (result) cycle while data memory is waiting.
module md_stall_ctr
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic MulDivE,
  input  logic MemWaitM,
  output logic mdStall,
  output logic MdBusy,
  output logic MdDoneE
);
  localparam bit MULTI = (MD_LAT >= 2);
  localparam logic [MD_CNT_W-1:0] CNT_LOAD = MULTI ? MD_CNT_W'(MD_LAT - 2) : {MD_CNT_W{1'b0}};

  md_state_e           state_r;
  logic [MD_CNT_W-1:0] cnt_r;

  // State and down-counter; the counter runs through memory waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= MD_IDLE;
      cnt_r   <= {MD_CNT_W{1'b0}};
    end else begin
      case (state_r)
        MD_IDLE: begin
          if (MulDivE && MULTI) begin
            state_r <= MD_BUSY;
            cnt_r   <= CNT_LOAD;
          end else begin
            state_r <= MD_IDLE;
            cnt_r   <= {MD_CNT_W{1'b0}};
          end
        end
        MD_BUSY: begin
          if (cnt_r != {MD_CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(MD_CNT_W-1){1'b0}}, 1'b1};
          end else if (!MemWaitM) begin
            state_r <= MD_IDLE;
          end else begin
            state_r <= MD_BUSY;
          end
        end
        default: begin
          state_r <= MD_IDLE;
          cnt_r   <= {MD_CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Stall/done decode; the first occupancy cycle stalls straight from IDLE.
  always_comb begin
    mdStall = 1'b0;
    MdDoneE = 1'b0;
    case (state_r)
      MD_IDLE: begin
        mdStall = MulDivE & MULTI;
        MdDoneE = MulDivE & ~MULTI;
      end
      MD_BUSY: begin
        mdStall = (cnt_r != {MD_CNT_W{1'b0}});
        MdDoneE = (cnt_r == {MD_CNT_W{1'b0}});
      end
      default: begin
        mdStall = 1'b0;
        MdDoneE = 1'b0;
      end
    endcase
  end

  assign MdBusy = (state_r == MD_BUSY);
endmodule

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: forwarding, load-use/RAW stalls, branch flushes,
// MUL/DIV occupancy and memory-wait freeze. HAZARD_FWD_EN enables forwarding.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  hazard_unit_mc_if.slave  hz
);
  localparam logic [REG_AW-1:0] X0 = {REG_AW{1'b0}};

  logic       mdStall_s, mdBusy_s, mdDone_s, hazStall_s;
  logic [1:0] fwdA_s, fwdB_s;

  md_stall_ctr #(.MD_LAT(MD_LAT)) uMdCtr (
    .clk      (clk),
    .rst      (rst),
    .MulDivE  (hz.MulDivE),
    .MemWaitM (hz.MemWaitM),
    .mdStall  (mdStall_s),
    .MdBusy   (mdBusy_s),
    .MdDoneE  (mdDone_s)
  );

`ifdef HAZARD_FWD_EN
  logic unusedFwd_s;
  assign unusedFwd_s = hz.RegWriteE;

  // MEM has the newer value, so it wins over WB.
  always_comb begin
    fwdA_s = FWD_REG;
    fwdB_s = FWD_REG;
    if (hz.RegWriteM && hz.RdM != X0 && hz.RdM == hz.Rs1E) begin
      fwdA_s = FWD_MEM;
    end else if (hz.RegWriteW && hz.RdW != X0 && hz.RdW == hz.Rs1E) begin
      fwdA_s = FWD_WB;
    end else begin
      fwdA_s = FWD_REG;
    end
    if (hz.RegWriteM && hz.RdM != X0 && hz.RdM == hz.Rs2E) begin
      fwdB_s = FWD_MEM;
    end else if (hz.RegWriteW && hz.RdW != X0 && hz.RdW == hz.Rs2E) begin
      fwdB_s = FWD_WB;
    end else begin
      fwdB_s = FWD_REG;
    end
    hazStall_s = (hz.ResultSrcE == RESULT_LOAD) && (hz.RdE != X0) &&
                 ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  end
`else
  logic unusedFwd_s;
  assign unusedFwd_s = ^{hz.Rs1E, hz.Rs2E, hz.RdW, hz.RegWriteW, hz.ResultSrcE};

  // No bypass paths: ID waits until EX and MEM producers have retired to WB.
  always_comb begin
    fwdA_s     = FWD_REG;
    fwdB_s     = FWD_REG;
    hazStall_s = (hz.RegWriteE && hz.RdE != X0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D)) ||
                 (hz.RegWriteM && hz.RdM != X0 && (hz.RdM == hz.Rs1D || hz.RdM == hz.Rs2D));
  end
`endif

  // Output priority: reset, then memory-wait freeze, then normal hazards.
  always_comb begin
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.StallM    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushM    = 1'b0;
    hz.FlushW    = 1'b0;
    hz.ForwardAE = FWD_REG;
    hz.ForwardBE = FWD_REG;
    hz.MdBusy    = 1'b0;
    hz.MdDoneE   = 1'b0;
    if (rst) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
      hz.FlushM = 1'b1;
      hz.FlushW = 1'b1;
    end else begin
      hz.ForwardAE = fwdA_s;
      hz.ForwardBE = fwdB_s;
      hz.MdBusy    = mdBusy_s;
      hz.MdDoneE   = mdDone_s;
      if (hz.MemWaitM) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.StallM = 1'b1;
        hz.FlushW = 1'b1;
      end else begin
        hz.StallF = hazStall_s | mdStall_s;
        hz.StallD = hazStall_s | mdStall_s;
        hz.StallE = mdStall_s;
        hz.FlushD = hz.PCSrcE;
        hz.FlushE = hz.PCSrcE | hazStall_s;
        hz.FlushM = mdStall_s;
      end
    end
  end
endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc (MD_LAT=4 main instance, MD_LAT=1 side instance).
module tb_hazard_unit_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hazard_unit_mc_if #(.REG_AW(5)) hz ();
  hazard_unit_mc_if #(.REG_AW(5)) hz1 ();

  hazard_unit_mc #(.REG_AW(5), .MD_LAT(4)) dut  (.clk(clk), .rst(rst), .hz(hz));
  hazard_unit_mc #(.REG_AW(5), .MD_LAT(1)) dut1 (.clk(clk), .rst(rst), .hz(hz1));

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW}
  function automatic logic [7:0] ctrl();
    ctrl = {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    {hz.Rs1D, hz.Rs2D, hz.Rs1E, hz.Rs2E, hz.RdE, hz.RdM, hz.RdW} = 35'd0;
    {hz.RegWriteE, hz.RegWriteM, hz.RegWriteW} = 3'b000;
    hz.ResultSrcE = 2'b00;
    {hz.PCSrcE, hz.MulDivE, hz.MemWaitM} = 3'b000;
    {hz1.Rs1D, hz1.Rs2D, hz1.Rs1E, hz1.Rs2E, hz1.RdE, hz1.RdM, hz1.RdW} = 35'd0;
    {hz1.RegWriteE, hz1.RegWriteM, hz1.RegWriteW} = 3'b000;
    hz1.ResultSrcE = 2'b00;
    {hz1.PCSrcE, hz1.MulDivE, hz1.MemWaitM} = 3'b000;
  endtask

  task automatic test_reset();
    clearIn();
    rst = 1'b1;
    hz.RegWriteM = 1'b1; hz.RdM = 5'd5; hz.Rs1E = 5'd5; hz.Rs2E = 5'd5;
    step(); step(); #1;
    checks++; if (ctrl() !== 8'b0000_1111) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl(), 8'b0000_1111); end
    checks++; if ({hz.ForwardAE, hz.ForwardBE} !== 4'b0000) begin errors++; $display("FAIL reset_fwd: got %b expected %b", {hz.ForwardAE, hz.ForwardBE}, 4'b0000); end
    checks++; if ({hz.MdBusy, hz.MdDoneE} !== 2'b00) begin errors++; $display("FAIL reset_md: got %b expected %b", {hz.MdBusy, hz.MdDoneE}, 2'b00); end
    rst = 1'b0;
    clearIn();
    step(); #1;
    checks++; if (ctrl() !== 8'b0000_0000) begin errors++; $display("FAIL post_reset_ctrl: got %b expected %b", ctrl(), 8'b0000_0000); end
  endtask

  task automatic test_forwarding();
    step(); clearIn();
    hz.RegWriteM = 1'b1; hz.RdM = 5'd5; hz.RegWriteW = 1'b1; hz.RdW = 5'd5; hz.Rs1E = 5'd5; hz.Rs2E = 5'd3;
    #1;
`ifdef HAZARD_FWD_EN
    checks++; if ({hz.ForwardAE, hz.ForwardBE} !== 4'b1000) begin errors++; $display("FAIL fwd_mem_prio: got %b expected %b", {hz.ForwardAE, hz.ForwardBE}, 4'b1000); end
    hz.RdM = 5'd0; #1;
    checks++; if (hz.ForwardAE !== 2'b01) begin errors++; $display("FAIL fwd_wb_x0m: got %b expected %b", hz.ForwardAE, 2'b01); end
    hz.Rs2E = 5'd5; #1;
    checks++; if (hz.ForwardBE !== 2'b01) begin errors++; $display("FAIL fwd_b_wb: got %b expected %b", hz.ForwardBE, 2'b01); end
    hz.RegWriteW = 1'b0; #1;
    checks++; if ({hz.ForwardAE, hz.ForwardBE} !== 4'b0000) begin errors++; $display("FAIL fwd_no_we: got %b expected %b", {hz.ForwardAE, hz.ForwardBE}, 4'b0000); end
`else
    checks++; if ({hz.ForwardAE, hz.ForwardBE} !== 4'b0000) begin errors++; $display("FAIL fwd_tied: got %b expected %b", {hz.ForwardAE, hz.ForwardBE}, 4'b0000); end
    clearIn(); hz.RdE = 5'd5; hz.RegWriteE = 1'b1; hz.Rs2D = 5'd5; #1;
    checks++; if (ctrl() !== 8'b1100_0100) begin errors++; $display("FAIL raw_e: got %b expected %b", ctrl(), 8'b1100_0100); end
    clearIn(); hz.RdM = 5'd6; hz.RegWriteM = 1'b1; hz.Rs1D = 5'd6; #1;
    checks++; if (ctrl() !== 8'b1100_0100) begin errors++; $display("FAIL raw_m: got %b expected %b", ctrl(), 8'b1100_0100); end
    clearIn(); hz.RdW = 5'd7; hz.RegWriteW = 1'b1; hz.Rs1D = 5'd7; #1;
    checks++; if (ctrl() !== 8'b0000_0000) begin errors++; $display("FAIL raw_w_nostall: got %b expected %b", ctrl(), 8'b0000_0000); end
`endif
  endtask

  task automatic test_load_use();
    step(); clearIn();
    hz.ResultSrcE = 2'b01; hz.RegWriteE = 1'b1; hz.RdE = 5'd7; hz.Rs1D = 5'd7; #1;
    checks++; if (ctrl() !== 8'b1100_0100) begin errors++; $display("FAIL lw_rs1: got %b expected %b", ctrl(), 8'b1100_0100); end
    step(); clearIn(); #1;
    checks++; if (ctrl() !== 8'b0000_0000) begin errors++; $display("FAIL lw_bubble: got %b expected %b", ctrl(), 8'b0000_0000); end
    step(); hz.ResultSrcE = 2'b01; hz.RegWriteE = 1'b1; hz.RdE = 5'd9; hz.Rs2D = 5'd9; #1;
    checks++; if (ctrl() !== 8'b1100_0100) begin errors++; $display("FAIL lw_rs2: got %b expected %b", ctrl(), 8'b1100_0100); end
    step(); hz.RdE = 5'd0; hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; #1;
    checks++; if (ctrl() !== 8'b0000_0000) begin errors++; $display("FAIL lw_x0: got %b expected %b", ctrl(), 8'b0000_0000); end
  endtask

  task automatic test_muldiv();
    logic [7:0] expC [4] = '{8'b1110_0010, 8'b1110_0010, 8'b1110_0010, 8'b0000_0000};
    logic [1:0] expM [4] = '{2'b00, 2'b10, 2'b10, 2'b11};
    step(); clearIn();
    hz.MulDivE = 1'b1; hz1.MulDivE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ctrl() !== expC[i]) begin errors++; $display("FAIL md_ctrl[%0d]: got %b expected %b", i, ctrl(), expC[i]); end
      checks++; if ({hz.MdBusy, hz.MdDoneE} !== expM[i]) begin errors++; $display("FAIL md_busy_done[%0d]: got %b expected %b", i, {hz.MdBusy, hz.MdDoneE}, expM[i]); end
      checks++; if ({hz1.StallE, hz1.MdBusy, hz1.MdDoneE} !== 3'b001) begin errors++; $display("FAIL md_lat1[%0d]: got %b expected %b", i, {hz1.StallE, hz1.MdBusy, hz1.MdDoneE}, 3'b001); end
      step();
    end
    hz.MulDivE = 1'b0; hz1.MulDivE = 1'b0; #1;
    checks++; if ({ctrl(), hz.MdBusy, hz.MdDoneE} !== 10'd0) begin errors++; $display("FAIL md_idle: got %b expected %b", {ctrl(), hz.MdBusy, hz.MdDoneE}, 10'd0); end
  endtask

  task automatic test_back_to_back();
    logic expS, expD;
    step(); clearIn();
    hz.MulDivE = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      expS = ((i % 4) != 3);
      expD = ((i % 4) == 3);
      checks++; if ({hz.StallE, hz.MdDoneE} !== {expS, expD}) begin errors++; $display("FAIL b2b[%0d]: got %b expected %b", i, {hz.StallE, hz.MdDoneE}, {expS, expD}); end
      step();
    end
    hz.MulDivE = 1'b0; #1;
    checks++; if (hz.MdBusy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected %b", hz.MdBusy, 1'b0); end
  endtask

  task automatic test_memwait_md();
    logic       mw   [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       md   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] expC [7] = '{8'b1110_0010, 8'b1111_0001, 8'b1110_0010, 8'b1111_0001,
                             8'b1111_0001, 8'b0000_0000, 8'b0000_0000};
    logic [1:0] expM [7] = '{2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00};
    step(); clearIn();
    for (int i = 0; i < 7; i++) begin
      hz.MemWaitM = mw[i]; hz.MulDivE = md[i]; #1;
      checks++; if (ctrl() !== expC[i]) begin errors++; $display("FAIL mw_ctrl[%0d]: got %b expected %b", i, ctrl(), expC[i]); end
      checks++; if ({hz.MdBusy, hz.MdDoneE} !== expM[i]) begin errors++; $display("FAIL mw_md[%0d]: got %b expected %b", i, {hz.MdBusy, hz.MdDoneE}, expM[i]); end
      step();
    end
  endtask

  task automatic test_branch_memwait();
    step(); clearIn();
    hz.PCSrcE = 1'b1; hz.MemWaitM = 1'b1; #1;
    checks++; if (ctrl() !== 8'b1111_0001) begin errors++; $display("FAIL br_wait: got %b expected %b", ctrl(), 8'b1111_0001); end
    step(); hz.MemWaitM = 1'b0; #1;
    checks++; if (ctrl() !== 8'b0000_1100) begin errors++; $display("FAIL br_release: got %b expected %b", ctrl(), 8'b0000_1100); end
    step(); clearIn();
    hz.ResultSrcE = 2'b01; hz.RegWriteE = 1'b1; hz.RdE = 5'd7; hz.Rs1D = 5'd7; hz.MemWaitM = 1'b1; #1;
    checks++; if (ctrl() !== 8'b1111_0001) begin errors++; $display("FAIL lw_wait: got %b expected %b", ctrl(), 8'b1111_0001); end
    step(); hz.MemWaitM = 1'b0; #1;
    checks++; if (ctrl() !== 8'b1100_0100) begin errors++; $display("FAIL lw_release: got %b expected %b", ctrl(), 8'b1100_0100); end
  endtask

  task automatic test_reset_busy();
    step(); clearIn();
    hz.MulDivE = 1'b1;
    step(); #1;
    checks++; if (hz.MdBusy !== 1'b1) begin errors++; $display("FAIL rb_busy: got %b expected %b", hz.MdBusy, 1'b1); end
    rst = 1'b1; #1;
    checks++; if ({ctrl(), hz.MdBusy, hz.MdDoneE} !== 10'b0000_1111_00) begin errors++; $display("FAIL rb_during: got %b expected %b", {ctrl(), hz.MdBusy, hz.MdDoneE}, 10'b0000_1111_00); end
    step(); rst = 1'b0; hz.MulDivE = 1'b0; #1;
    checks++; if ({ctrl(), hz.MdBusy, hz.MdDoneE} !== 10'd0) begin errors++; $display("FAIL rb_after: got %b expected %b", {ctrl(), hz.MdBusy, hz.MdDoneE}, 10'd0); end
    step(); #1;
    checks++; if ({ctrl(), hz.MdBusy} !== 9'd0) begin errors++; $display("FAIL rb_after2: got %b expected %b", {ctrl(), hz.MdBusy}, 9'd0); end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_muldiv();
    test_back_to_back();
    test_memwait_md();
    test_branch_memwait();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Parametrised hazard unit for the 5-stage RISC-V pipeline, the successor to the combinational load-use/branch hazard logic. It adds EX→ID/EX forwarding select generation and a multi-cycle MUL/DIV occupancy counter that holds the front end. It also handles variable-latency data-memory wait stalls. It sits beside the datapath and drives all pipeline-register stall and flush enables.

## Interface
Parameters:
- REG_AW, 5, register-index width
- MD_LAT, 4, EX occupancy of a MUL/DIV instruction in cycles; legal range 1..16

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- Rs1D, Rs2D  in  REG_AW  source registers in ID
- Rs1E, Rs2E  in  REG_AW  source registers in EX
- RdE, RdM, RdW  in  REG_AW  destination registers in EX/MEM/WB
- RegWriteE, RegWriteM, RegWriteW  in  1  write-enable per stage
- ResultSrcE  in  2  result mux select; 2'b01 = load
- PCSrcE  in  1  taken branch/jump resolved in EX
- MulDivE  in  1  EX holds a MUL/DIV instruction
- MemWaitM  in  1  data memory not ready for the MEM-stage access
- StallF, StallD, StallE, StallM  out  1  hold the PC and the IF/ID, ID/EX, EX/MEM registers
- FlushD, FlushE, FlushM, FlushW  out  1  insert a bubble into the IF/ID, ID/EX, EX/MEM, MEM/WB registers
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 = regfile, 01 = WB, 10 = MEM
- MdBusy  out  1  MUL/DIV occupancy in progress
- MdDoneE  out  1  MUL/DIV result valid in EX this cycle

## Operation
- **Forwarding (ForwardAE):** 10 if RegWriteM & RdM≠0 & RdM==Rs1E; else 01 if RegWriteW & RdW≠0 & RdW==Rs1E; else 00. ForwardBE is the same using Rs2E.
- **Load-use stall:** lwStall = ResultSrcE==2'b01 & RdE≠0 & (RdE==Rs1D | RdE==Rs2D).
  - Effect: StallF = StallD = 1 and FlushE = 1.
- **MUL/DIV state machine (IDLE, BUSY), 4-bit down-counter cnt:**
  - IDLE & MulDivE & MD_LAT≥2: mdStall = 1. Next state is BUSY with cnt = MD_LAT−2.
  - BUSY & cnt≠0: mdStall = 1 and cnt decrements.
  - BUSY & cnt==0: mdStall = 0 and MdDoneE = 1. Next state is IDLE when MemWaitM = 0; otherwise the unit stays in BUSY.
  - MD_LAT==1: the FSM never leaves IDLE, and MdDoneE = MulDivE.
  - mdStall effect: StallF = StallD = StallE = 1 and FlushM = 1 (bubble into MEM).
  - MdBusy = (state==BUSY).
- **Memory wait (MemWaitM=1), highest priority:**
  - StallF, StallD, StallE and StallM are all 1, and FlushW = 1.
  - FlushD, FlushE and FlushM are forced to 0, so PCSrcE and lwStall flushes are deferred until the wait clears.
  - The MUL/DIV counter keeps counting.
- **Branch/jump:** PCSrcE sets FlushD = FlushE = 1 when MemWaitM = 0.
  - PCSrcE cannot coincide with lwStall or mdStall: EX holds exactly one instruction.
- **Reset (rst=1):**
  - FSM goes to IDLE and cnt to 0.
  - Outputs during reset: FlushD, FlushE, FlushM and FlushW are 1; all stalls are 0; ForwardAE, ForwardBE, MdBusy and MdDoneE are 0.
  - Reset during BUSY abandons the operation.

## Timing
- Forwarding, load-use, branch and memory-wait outputs are combinational from inputs, with zero-cycle latency.
- A MUL/DIV instruction occupies EX for exactly MD_LAT cycles with MemWaitM=0.
  - It advances to MEM at the clock edge ending the MdDoneE cycle.
  - Each MemWaitM cycle during BUSY & cnt==0 extends the occupancy by one cycle.
- A back-to-back MUL/DIV re-enters BUSY on the cycle after returning to IDLE.
- A load-use stall lasts one cycle; a wait-extended load keeps lwStall asserted until it leaves EX.

## Configuration
- **HAZARD_FWD_EN defined:** forwarding as described above.
- **HAZARD_FWD_EN undefined:**
  - ForwardAE and ForwardBE are tied to 00.
  - rawStall = any X in {E,M} with RegWriteX & RdX≠0 & RdX∈{Rs1D,Rs2D}.
    - The register file writes on the falling edge, so WB needs no stall.
  - rawStall replaces lwStall with the same effect (StallF, StallD, FlushE).

## Structure
- **Package hazard_pkg:**
  - fwd_sel_e {FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}
  - RESULT_LOAD = 2'b01
  - md_state_e {MD_IDLE, MD_BUSY}
- **Sub-module md_stall_ctr:** contains the FSM and counter.
  - Inputs: clk, rst, MulDivE, MemWaitM.
  - Outputs: mdStall, MdBusy, MdDoneE.
  - Parameter: MD_LAT.

## Test plan
- **RAW forwarding:** RdM=5 and RdW=5 (both writing), Rs1E=5 → ForwardAE=10; RdM=0, RdW=5 → ForwardAE=01. Without HAZARD_FWD_EN: RdE=5, RegWriteE, Rs2D=5 → StallF=StallD=FlushE=1.
- **Load-use:** ResultSrcE=01, RdE=7, Rs1D=7 → one cycle of StallF=StallD=FlushE=1; RdE=0 → no stall.
- **MUL/DIV, MD_LAT=4:** MulDivE pulse → StallE=1 for 3 cycles, MdDoneE=1 on cycle 4, FlushM=1 for 3 cycles. MD_LAT=1 → no stall.
- **MemWaitM during MUL/DIV:** MemWaitM=1 on the cnt==0 cycle for 2 cycles → FSM holds BUSY, StallM=FlushW=1, IDLE one cycle after MemWaitM drops.
- **Branch during memory wait:** PCSrcE=1 with MemWaitM=1 → FlushD=FlushE=0; MemWaitM falls → FlushD=FlushE=1 that cycle.
- **Reset mid-BUSY:** rst=1 in the second busy cycle → MdBusy=0 the next cycle, all flushes=1 during reset, no stalls after release.
